// File: rtl/branch_redirect_unit.sv
// Branch redirect unit: owns the architectural PC, resolves taken/not-taken and drives a
// registered fetch redirect followed by a flush window. Optional trap: BRANCH_MISALIGN_TRAP_EN.
module branch_redirect_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] instr,
  input  logic [1:0]  branch_op,
  input  logic [2:0]  branch_base_src,
  input  logic [2:0]  branch_offset_src,
  input  logic        alu_zero,
  input  logic [31:0] rs1_data,
  output logic [31:0] pc,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
`ifdef BRANCH_MISALIGN_TRAP_EN
  output logic        trap_valid,
  output logic [31:0] trap_addr,
  input  logic        trap_ack,
`endif
  output logic        flush
);

  typedef enum logic [1:0] {ST_RUN, ST_REDIRECT, ST_FLUSH, ST_TRAP} state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        redirectValid_q, redirectValid_d;
  logic [31:0] redirectPc_q, redirectPc_d;
  logic [3:0]  flushCnt_q, flushCnt_d;
`ifdef BRANCH_MISALIGN_TRAP_EN
  logic        trapValid_q, trapValid_d;
  logic [31:0] trapAddr_q, trapAddr_d;
`endif

  logic        taken;
  logic [31:0] target;

  function automatic logic [31:0] srcSel(input logic [2:0] sel, input logic [31:0] pcVal,
                                         input logic [31:0] ins, input logic [31:0] rs1);
    logic [31:0] val;
    case (sel)
      3'b000:  val = 32'd0;
      3'b001:  val = pcVal + 32'd4;
      3'b010:  val = pcVal;
      3'b011:  val = rs1;
      3'b100:  val = {{20{ins[31]}}, ins[31:20]};
      3'b101:  val = {ins[31:12], 12'b0};
      3'b110:  val = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: val = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    endcase
    return val;
  endfunction

  // Unknown or 00 ops fall through to the default and never redirect.
  always_comb begin
    taken = 1'b0;
    case (branch_op)
      2'b01:   taken = !alu_zero;
      2'b10:   taken = alu_zero;
      2'b11:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
    target = (srcSel(branch_base_src, pc_q, instr, rs1_data) +
              srcSel(branch_offset_src, pc_q, instr, rs1_data)) & 32'hFFFF_FFFE;
  end

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    redirectValid_d = redirectValid_q;
    redirectPc_d    = redirectPc_q;
    flushCnt_d      = flushCnt_q;
`ifdef BRANCH_MISALIGN_TRAP_EN
    trapValid_d     = trapValid_q;
    trapAddr_d      = trapAddr_q;
`endif
    case (state_q)
      ST_RUN: begin
        if (ex_valid && taken) begin
`ifdef BRANCH_MISALIGN_TRAP_EN
          if (target[1]) begin
            trapValid_d = 1'b1;
            trapAddr_d  = target;
            state_d     = ST_TRAP;
          end else begin
`else
          begin
`endif
            pc_d            = target;
            redirectPc_d    = target;
            redirectValid_d = 1'b1;
            state_d         = ST_REDIRECT;
          end
        end else if (ex_valid) begin
          pc_d = pc_q + 32'd4;
        end
      end
      ST_REDIRECT: begin
        if (redirect_ready) begin
          redirectValid_d = 1'b0;
          flushCnt_d      = FLUSH_LOAD;
          state_d         = (FLUSH_CYCLES == 0) ? ST_RUN : ST_FLUSH;
        end
      end
      // Leaving on the count of 1 gives exactly FLUSH_CYCLES cycles of flush.
      ST_FLUSH: begin
        flushCnt_d = flushCnt_q - 4'd1;
        if (flushCnt_q <= 4'd1) begin
          flushCnt_d = 4'd0;
          state_d    = ST_RUN;
        end
      end
`ifdef BRANCH_MISALIGN_TRAP_EN
      ST_TRAP: begin
        if (trap_ack) begin
          trapValid_d = 1'b0;
          state_d     = ST_RUN;
        end
      end
`endif
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_RUN;
      pc_q            <= RESET_PC;
      redirectValid_q <= 1'b0;
      redirectPc_q    <= 32'd0;
      flushCnt_q      <= 4'd0;
`ifdef BRANCH_MISALIGN_TRAP_EN
      trapValid_q     <= 1'b0;
      trapAddr_q      <= 32'd0;
`endif
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      redirectValid_q <= redirectValid_d;
      redirectPc_q    <= redirectPc_d;
      flushCnt_q      <= flushCnt_d;
`ifdef BRANCH_MISALIGN_TRAP_EN
      trapValid_q     <= trapValid_d;
      trapAddr_q      <= trapAddr_d;
`endif
    end
  end

  assign ex_ready       = (state_q == ST_RUN);
  assign flush          = (state_q == ST_FLUSH);
  assign pc             = pc_q;
  assign redirect_valid = redirectValid_q;
  assign redirect_pc    = redirectPc_q;
`ifdef BRANCH_MISALIGN_TRAP_EN
  assign trap_valid     = trapValid_q;
  assign trap_addr      = trapAddr_q;
`endif

endmodule

// File: doc/branch_redirect_unit.md
Name: branch_redirect_unit

Overview:
- Consumes the branch-select control word produced by instruction decode: branch_op, branch_base_src and branch_offset_src, together with the raw instruction, the ALU zero flag and the rs1 value.
- Owns the architectural PC register and resolves taken/not-taken for each retiring instruction.
- On a taken branch or jump, issues a registered redirect to fetch over a valid/ready handshake, then holds a flush window that squashes younger instructions.
- Sits between the execute stage and the fetch PC mux.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FLUSH_CYCLES, 2, bubble cycles after redirect acceptance (0..15; 0 = no flush window).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ex_valid  in  1  an execute-stage instruction is presented.
- ex_ready  out  1  the unit accepts the instruction this cycle.
- instr  in  32  instruction word of the presented instruction.
- branch_op  in  2  00 never, 01 taken if ALU result non-zero, 10 taken if ALU result zero, 11 always.
- branch_base_src  in  3  base operand select (encoding below).
- branch_offset_src  in  3  offset operand select (encoding below).
- alu_zero  in  1  ALU result == 0 for the presented instruction.
- rs1_data  in  32  register operand value.
- pc  out  32  current architectural PC.
- redirect_valid  out  1  redirect request to fetch.
- redirect_pc  out  32  redirect target; stable while redirect_valid=1.
- redirect_ready  in  1  fetch accepts the redirect.
- flush  out  1  squash younger instructions.

Behaviour:
- Source encoding, applies to both selects:
  - 000 = 0
  - 001 = pc+4
  - 010 = pc
  - 011 = rs1_data
  - 100 = sext(instr[31:20])
  - 101 = {instr[31:12],12'b0}
  - 110 = J-immediate sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0})
  - 111 = B-immediate sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0})
- target = (base + offset) mod 2^32, then bit0 is forced to 0.
- taken:
  - op 00 -> 0
  - op 01 -> !alu_zero
  - op 10 -> alu_zero
  - op 11 -> 1
- States: RUN, REDIRECT, FLUSH.
- RUN:
  - ex_ready=1; flush=0; redirect_valid=0.
  - On ex_valid && !taken: pc <= pc+4 on the next edge.
  - On ex_valid && taken: pc <= target, redirect_pc <= target and redirect_valid <= 1 on the next edge; go to REDIRECT.
- REDIRECT:
  - ex_ready=0; redirect_valid=1; redirect_pc is held.
  - On redirect_ready: redirect_valid <= 0; load the flush counter with FLUSH_CYCLES; go to FLUSH, or to RUN if FLUSH_CYCLES=0.
- FLUSH:
  - ex_ready=0; flush=1; the counter decrements each cycle.
  - Go to RUN on the edge where the counter reaches 1. Exactly FLUSH_CYCLES cycles have flush=1.
- ex_valid while ex_ready=0 is ignored; pc is unchanged in REDIRECT and FLUSH.
- pc wraps: 32'hFFFF_FFFC + 4 = 0.
- An undefined branch_op (X) is treated as 00.
- Reset values (asynchronous, any state including mid-REDIRECT or mid-FLUSH):
  - pc = RESET_PC
  - state = RUN
  - redirect_valid = 0
  - redirect_pc = 0
  - flush = 0
  - counter = 0
- Latency: a taken instruction accepted at edge N has redirect_valid=1 from N+1.

Optional Feature:
- Macro: BRANCH_MISALIGN_TRAP_EN.
- When defined:
  - Adds ports trap_valid (out 1), trap_addr (out 32) and trap_ack (in 1), plus a TRAP state.
  - A taken instruction with target[1]=1 does not redirect. pc is unchanged, trap_addr <= target, trap_valid <= 1 and the state goes to TRAP.
  - In TRAP, ex_ready=0. On trap_ack, trap_valid <= 0 and the state returns to RUN.
  - Reset clears trap_valid and trap_addr.
- When undefined: those ports are absent and misaligned targets redirect normally.

Test Plan:
- Reset with RESET_PC=32'h100, rst_n low mid-cycle -> pc=32'h100 and redirect_valid=0 immediately, asynchronously.
- Non-taken: op=10, alu_zero=0, ex_valid for 3 cycles from pc=32'h100 -> pc 32'h104, 32'h108, 32'h10C; no redirect.
- Jump with stall: instr=32'h0080006F, op=11, base=010, offset=110, pc=32'h100, redirect_ready low for 2 cycles -> redirect_valid=1 with redirect_pc=32'h108 held 3 cycles. After acceptance, flush=1 for exactly 2 cycles, then ex_ready=1 and pc=32'h108.
- Register jump: op=11, base=011, offset=100, rs1_data=32'h2001, instr[31:20]=12'h004 -> redirect_pc=32'h2004 (bit0 cleared).
- Wrap: pc=32'hFFFF_FFFC, non-taken -> pc=0. In the same run, assert rst_n low during FLUSH -> state RUN, flush=0.
- With BRANCH_MISALIGN_TRAP_EN: op=11, base=011, offset=000, rs1_data=32'h3002 -> trap_valid=1, trap_addr=32'h3002, no redirect, pc unchanged; trap_ack returns the unit to RUN.
